// File: rtl/hdmi_tx_gearbox.sv
`default_nettype none
// ============================================================================
//  Module      : hdmi_tx_gearbox
//  Description : 5x-pixel-clock scheduler that slices three 10-bit TMDS
//                symbols into 2-bit DDR pairs (bit 0 first), drives the fixed
//                TMDS clock pattern on the clock lane, and substitutes the
//                idle control token when no symbol is available at a symbol
//                boundary. One-deep shadow register decouples the upstream
//                valid/ready handshake from the symbol boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module hdmi_tx_gearbox (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_ch0,
    input  logic [9:0] in_ch1,
    input  logic [9:0] in_ch2,
    output logic [1:0] out_ch0,
    output logic [1:0] out_ch1,
    output logic [1:0] out_ch2,
    output logic [1:0] out_chc,
    output logic       sym_start,
    output logic       underflow
);

    localparam logic [9:0]  CTRL_IDLE   = 10'b1101010100;
    localparam logic [9:0]  CLK_PATTERN = 10'b0000011111;
    localparam logic [2:0]  LAST_PHASE  = 3'd4;
    localparam logic [29:0] IDLE_WORD   = {CTRL_IDLE, CTRL_IDLE, CTRL_IDLE};

    // Returns pair number idx ({bit 2idx+1, bit 2idx}) of a 10-bit symbol.
    function automatic logic [1:0] pair_of(input logic [9:0] sym, input logic [2:0] idx);
        logic [1:0] p;
        case (idx)
            3'd0:    p = sym[1:0];
            3'd1:    p = sym[3:2];
            3'd2:    p = sym[5:4];
            3'd3:    p = sym[7:6];
            default: p = sym[9:8];
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]  phase_q,       phase_d;
    logic [29:0] sreg_q,        sreg_d;
    logic [29:0] shadow_q,      shadow_d;
    logic        shadow_full_q, shadow_full_d;
    logic [1:0]  out_ch0_q,     out_ch0_d;
    logic [1:0]  out_ch1_q,     out_ch1_d;
    logic [1:0]  out_ch2_q,     out_ch2_d;
    logic [1:0]  out_chc_q,     out_chc_d;
    logic        sym_start_q,   sym_start_d;
    logic        underflow_q,   underflow_d;

    logic        w_load;
    logic        w_xfer;
    logic [29:0] w_in_word;
    logic [29:0] w_next_word;
    logic [2:0]  w_pair_idx;

    assign w_load    = (phase_q == LAST_PHASE);
    assign w_in_word = {in_ch2, in_ch1, in_ch0};

    // The shadow may be refilled on the very edge it drains, so ready is
    // also asserted at the load edge even when the shadow is occupied.
    assign in_ready  = en & (~shadow_full_q | w_load);
    assign w_xfer    = in_valid & in_ready;

    assign w_pair_idx = w_load ? 3'd0 : (phase_q + 3'd1);

    // Next-state computation: word selection at boundaries, pair slicing otherwise.
    always_comb begin
        phase_d       = phase_q;
        sreg_d        = sreg_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;
        sym_start_d   = 1'b0;
        underflow_d   = 1'b0;
        w_next_word   = sreg_q;

        if (w_load) begin
            if (!en) begin
                // Disabled: idle token, and any buffered symbol is dropped.
                w_next_word   = IDLE_WORD;
                shadow_d      = '0;
                shadow_full_d = 1'b0;
            end else if (shadow_full_q) begin
                w_next_word = shadow_q;
                if (w_xfer) begin
                    shadow_d      = w_in_word;
                    shadow_full_d = 1'b1;
                end else begin
                    shadow_full_d = 1'b0;
                end
            end else if (w_xfer) begin
                // Empty shadow: bypass straight into the shift register.
                w_next_word = w_in_word;
            end else begin
                w_next_word = IDLE_WORD;
                underflow_d = 1'b1;
            end
            sreg_d      = w_next_word;
            phase_d     = 3'd0;
            sym_start_d = 1'b1;
        end else begin
            phase_d = phase_q + 3'd1;
            if (w_xfer) begin
                shadow_d      = w_in_word;
                shadow_full_d = 1'b1;
            end
        end

        out_ch0_d = pair_of(w_next_word[9:0],   w_pair_idx);
        out_ch1_d = pair_of(w_next_word[19:10], w_pair_idx);
        out_ch2_d = pair_of(w_next_word[29:20], w_pair_idx);
        out_chc_d = pair_of(CLK_PATTERN,        w_pair_idx);
    end

    // State and registered outputs; reset aborts any symbol in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q       <= LAST_PHASE;
            sreg_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            out_ch0_q     <= 2'b00;
            out_ch1_q     <= 2'b00;
            out_ch2_q     <= 2'b00;
            out_chc_q     <= 2'b00;
            sym_start_q   <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            sreg_q        <= sreg_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            out_ch0_q     <= out_ch0_d;
            out_ch1_q     <= out_ch1_d;
            out_ch2_q     <= out_ch2_d;
            out_chc_q     <= out_chc_d;
            sym_start_q   <= sym_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign out_ch0   = out_ch0_q;
    assign out_ch1   = out_ch1_q;
    assign out_ch2   = out_ch2_q;
    assign out_chc   = out_chc_q;
    assign sym_start = sym_start_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire
